// File: rtl/seq_alu_pkg.sv
// seq_alu shared definitions: opcodes, FSM states,
// op classification and flag bundle.
package alu_pkg;

  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_SUB  = 6'b100010;
  localparam logic [5:0] OP_AND  = 6'b100100;
  localparam logic [5:0] OP_OR   = 6'b100101;
  localparam logic [5:0] OP_XOR  = 6'b100110;
  localparam logic [5:0] OP_NOR  = 6'b100111;
  localparam logic [5:0] OP_SLT  = 6'b101010;
  localparam logic [5:0] OP_SLTU = 6'b101011;
  localparam logic [5:0] OP_SLL  = 6'b000000;
  localparam logic [5:0] OP_SRL  = 6'b000010;
  localparam logic [5:0] OP_SRA  = 6'b000011;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    CL_SHIFT,
    CL_ARITH,
    CL_LOGIC,
    CL_ILLEGAL
  } op_class_e;

  typedef enum logic [1:0] {
    SH_SLL,
    SH_SRL,
    SH_SRA
  } sh_kind_e;

  typedef struct packed {
    logic ovf;
    logic carry;
    logic zero;
    logic neg;
    logic ill;
  } flags_t;

  function automatic op_class_e op_class(
    input logic [5:0] op
  );
    op_class_e c;
    c = CL_ILLEGAL;
    unique case (1'b1)
      (op == OP_SLL),
      (op == OP_SRL),
      (op == OP_SRA):  c = CL_SHIFT;
      (op == OP_ADD),
      (op == OP_SUB),
      (op == OP_SLT),
      (op == OP_SLTU): c = CL_ARITH;
      (op == OP_AND),
      (op == OP_OR),
      (op == OP_XOR),
      (op == OP_NOR):  c = CL_LOGIC;
      default:         c = CL_ILLEGAL;
    endcase
    return c;
  endfunction

  function automatic sh_kind_e sh_kind(
    input logic [5:0] op
  );
    sh_kind_e k;
    k = SH_SRA;
    unique case (1'b1)
      (op == OP_SLL): k = SH_SLL;
      (op == OP_SRL): k = SH_SRL;
      default:        k = SH_SRA;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/seq_alu_shifter.sv
// Iterative shifter: one bit per cycle, done flags
// the cycle whose edge produces the final value.
module seq_alu_shifter
  import alu_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  localparam int SHAMT_W = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [SHAMT_W-1:0]    shamt_i,
  input  sh_kind_e              kind_i,
  output logic [DATA_WIDTH-1:0] step_o,
  output logic                  done_o
);

  localparam int W = DATA_WIDTH;

  logic [W-1:0]       work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  sh_kind_e           kind_q, kind_d;
  logic [W-1:0]       step;

  always_comb begin
    case (kind_q)
      SH_SLL:  step = {work_q[W-2:0], 1'b0};
      SH_SRL:  step = {1'b0, work_q[W-1:1]};
      default: step = {work_q[W-1], work_q[W-1:1]};
    endcase
  end

  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    kind_d = kind_q;
    if (load_i) begin
      work_d = a_i;
      cnt_d  = shamt_i;
      kind_d = kind_i;
    end else if (cnt_q != '0) begin
      work_d = step;
      cnt_d  = cnt_q - SHAMT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q <= '0;
      cnt_q  <= '0;
      kind_q <= SH_SLL;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      kind_q <= kind_d;
    end
  end

  assign step_o = step;
  assign done_o = (cnt_q == SHAMT_W'(1));

endmodule

// File: rtl/seq_alu.sv
// Registered, handshaked ALU with iterative shifts.
// Optional sticky overflow: SEQ_ALU_STICKY_FLAGS_EN.
module seq_alu
  import alu_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  localparam int SHAMT_W = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [5:0]            op,
  input  logic [SHAMT_W-1:0]    shamt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic                  carry,
  output logic                  zero,
  output logic                  negative,
  output logic                  illegal,
`ifdef SEQ_ALU_STICKY_FLAGS_EN
  input  logic                  sticky_clr,
  output logic                  sticky_ovf,
`endif
  output logic                  busy
);

  localparam int W = DATA_WIDTH;

  state_e       state_q, state_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] result_q, result_d;
  flags_t       flags_q, flags_d;

  op_class_e    cls;
  logic         xfer;
  logic         long_shift;
  logic         wr;
  logic         sh_done;
  logic [W-1:0] sh_step;
  logic [W:0]   sum;
  logic [W:0]   diff;
  logic [W-1:0] imm_res;
  flags_t       imm_flg;

  assign cls        = op_class(op);
  assign long_shift = (cls == CL_SHIFT) && (shamt != '0);
  assign xfer       = in_valid && in_ready;
  assign sum        = {1'b0, a} + {1'b0, b};
  assign diff       = {1'b0, a} - {1'b0, b};

  seq_alu_shifter #(
    .DATA_WIDTH(W)
  ) u_shifter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (xfer && long_shift),
    .a_i    (a),
    .shamt_i(shamt),
    .kind_i (sh_kind(op)),
    .step_o (sh_step),
    .done_o (sh_done)
  );

  always_comb begin
    imm_res = '0;
    imm_flg = '0;
    unique case (1'b1)
      (op == OP_ADD): begin
        imm_res       = sum[W-1:0];
        imm_flg.carry = sum[W];
        imm_flg.ovf   = (a[W-1] == b[W-1]) &&
                        (sum[W-1] != a[W-1]);
      end
      (op == OP_SUB): begin
        imm_res       = diff[W-1:0];
        imm_flg.carry = ~diff[W];
        imm_flg.ovf   = (a[W-1] != b[W-1]) &&
                        (diff[W-1] != a[W-1]);
      end
      (op == OP_AND):  imm_res = a & b;
      (op == OP_OR):   imm_res = a | b;
      (op == OP_XOR):  imm_res = a ^ b;
      (op == OP_NOR):  imm_res = ~(a | b);
      (op == OP_SLT):
        imm_res[0] = $signed(a) < $signed(b);
      (op == OP_SLTU): imm_res[0] = a < b;
      (cls == CL_SHIFT): imm_res = a;
      default: imm_flg.ill = 1'b1;
    endcase
    imm_flg.zero = (imm_res == '0);
    imm_flg.neg  = imm_res[W-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (xfer && long_shift) state_d = SHIFT;
      SHIFT:
        if (sh_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == SHIFT);
    in_ready = (state_q != SHIFT) &&
               (!out_valid_q || out_ready);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    wr          = 1'b0;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (xfer) begin
      if (long_shift) begin
        out_valid_d = 1'b0;
      end else begin
        wr          = 1'b1;
        result_d    = imm_res;
        flags_d     = imm_flg;
        out_valid_d = 1'b1;
      end
    end else if ((state_q == SHIFT) && sh_done) begin
      wr           = 1'b1;
      result_d     = sh_step;
      flags_d      = '0;
      flags_d.zero = (sh_step == '0);
      flags_d.neg  = sh_step[W-1];
      out_valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

`ifdef SEQ_ALU_STICKY_FLAGS_EN
  logic sticky_q, sticky_d;

  // A setting event in the same cycle as a clear wins.
  always_comb begin
    sticky_d = sticky_q;
    if (wr && (flags_d.ovf || flags_d.ill))
      sticky_d = 1'b1;
    else if (sticky_clr)
      sticky_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_ovf = sticky_q;
`else
  logic unused_wr;
  assign unused_wr = wr;
`endif

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = flags_q.ovf;
  assign carry     = flags_q.carry;
  assign zero      = flags_q.zero;
  assign negative  = flags_q.neg;
  assign illegal   = flags_q.ill;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: behavioural model,
// per-cycle compare, directed literal checks, random.
module tb_seq_alu;

  localparam logic [5:0] ADD  = 6'b100000;
  localparam logic [5:0] SUB  = 6'b100010;
  localparam logic [5:0] AND_ = 6'b100100;
  localparam logic [5:0] OR_  = 6'b100101;
  localparam logic [5:0] XOR_ = 6'b100110;
  localparam logic [5:0] NOR_ = 6'b100111;
  localparam logic [5:0] SLT  = 6'b101010;
  localparam logic [5:0] SLTU = 6'b101011;
  localparam logic [5:0] SLL  = 6'b000000;
  localparam logic [5:0] SRL  = 6'b000010;
  localparam logic [5:0] SRA  = 6'b000011;

  logic       clk = 0;
  logic       rst_n = 0;
  logic       in_valid = 0;
  logic       in_ready;
  logic [7:0] a = 0;
  logic [7:0] b = 0;
  logic [5:0] op = 0;
  logic [2:0] shamt = 0;
  logic       out_valid;
  logic       out_ready = 1;
  logic [7:0] result;
  logic       overflow, carry, zero;
  logic       negative, illegal, busy;
  logic       sticky_clr = 0;
`ifdef SEQ_ALU_STICKY_FLAGS_EN
  logic       sticky_ovf;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_alu #(.DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .carry     (carry),
    .zero      (zero),
    .negative  (negative),
    .illegal   (illegal),
`ifdef SEQ_ALU_STICKY_FLAGS_EN
    .sticky_clr(sticky_clr),
    .sticky_ovf(sticky_ovf),
`endif
    .busy      (busy)
  );

  typedef struct packed {
    logic [7:0] res;
    logic ovf, carry, zero, neg, ill;
  } exp_t;

  function automatic bit is_shift(logic [5:0] o);
    return o == SLL || o == SRL || o == SRA;
  endfunction

  function automatic exp_t golden(
    logic [5:0] o, logic [7:0] x, logic [7:0] y, int s
  );
    exp_t e;
    int ux, uy, sx, sy, r;
    e  = '0;
    ux = x;
    uy = y;
    sx = x[7] ? ux - 256 : ux;
    sy = y[7] ? uy - 256 : uy;
    r  = 0;
    case (o)
      ADD: begin
        r = ux + uy;
        e.carry = r > 255;
        e.ovf = (sx + sy > 127) || (sx + sy < -128);
      end
      SUB: begin
        r = ux - uy;
        e.carry = ux >= uy;
        e.ovf = (sx - sy > 127) || (sx - sy < -128);
      end
      AND_: r = ux & uy;
      OR_:  r = ux | uy;
      XOR_: r = ux ^ uy;
      NOR_: r = ~(ux | uy);
      SLT:  r = (sx < sy) ? 1 : 0;
      SLTU: r = (ux < uy) ? 1 : 0;
      SLL:  r = ux << s;
      SRL:  r = ux >> s;
      SRA:  r = sx >>> s;
      default: e.ill = 1;
    endcase
    e.res  = r[7:0];
    e.zero = (e.res == 0);
    e.neg  = e.res[7];
    return e;
  endfunction

  bit   m_valid;
  bit   m_sticky;
  bit   m_rdy;
  bit   m_wr;
  int   m_cnt;
  exp_t m_out, m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid  = 0;
      m_cnt    = 0;
      m_sticky = 0;
      m_out    = '0;
    end else begin
      m_rdy = (m_cnt == 0) && (!m_valid || out_ready);
      m_wr  = 0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_valid = 1;
          m_out   = m_pend;
          m_wr    = 1;
        end
      end else begin
        if (m_valid && out_ready) m_valid = 0;
        if (in_valid && m_rdy) begin
          if (is_shift(op) && shamt != 0) begin
            m_cnt   = shamt;
            m_pend  = golden(op, a, b, shamt);
            m_valid = 0;
          end else begin
            m_out   = golden(op, a, b, shamt);
            m_valid = 1;
            m_wr    = 1;
          end
        end
      end
      if (m_wr && (m_out.ovf || m_out.ill))
        m_sticky = 1;
      else if (sticky_clr)
        m_sticky = 0;
    end
  end

  task automatic chk(
    input string nm, input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("busy", 32'(busy), 32'(m_cnt > 0));
      chk("in_ready", 32'(in_ready),
          32'((m_cnt == 0) && (!m_valid || out_ready)));
      if (m_valid) begin
        chk("result", 32'(result), 32'(m_out.res));
        chk("overflow", 32'(overflow), 32'(m_out.ovf));
        chk("carry", 32'(carry), 32'(m_out.carry));
        chk("zero", 32'(zero), 32'(m_out.zero));
        chk("negative", 32'(negative), 32'(m_out.neg));
        chk("illegal", 32'(illegal), 32'(m_out.ill));
      end
`ifdef SEQ_ALU_STICKY_FLAGS_EN
      chk("sticky_ovf", 32'(sticky_ovf), 32'(m_sticky));
`endif
    end
  end

  task automatic issue(
    input logic [5:0] o, input logic [7:0] x,
    input logic [7:0] y, input logic [2:0] s
  );
    bit ok;
    ok = 0;
    in_valid = 1;
    op = o;
    a = x;
    b = y;
    shamt = s;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    chk("issue_accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic lit(
    input string nm, input logic [7:0] r,
    input bit v, input bit c, input bit z,
    input bit n, input bit il
  );
    chk({nm, "_res"}, 32'(result), 32'(r));
    chk({nm, "_ovf"}, 32'(overflow), 32'(v));
    chk({nm, "_carry"}, 32'(carry), 32'(c));
    chk({nm, "_zero"}, 32'(zero), 32'(z));
    chk({nm, "_neg"}, 32'(negative), 32'(n));
    chk({nm, "_ill"}, 32'(illegal), 32'(il));
  endtask

  task automatic run_op(
    input string nm, input logic [5:0] o,
    input logic [7:0] x, input logic [7:0] y,
    input logic [2:0] s, input logic [7:0] r,
    input bit v, input bit c, input bit z,
    input bit n, input bit il
  );
    bit got;
    got = 0;
    issue(o, x, y, s);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = out_valid;
    end
    chk({nm, "_valid"}, 32'(got), 32'd1);
    lit(nm, r, v, c, z, n, il);
    @(posedge clk);
    #1;
  endtask

  logic [5:0] ops [14];
  bit rdy;
  int nb, lat;
  bit got;

  initial begin
    ops = '{ADD, SUB, AND_, OR_, XOR_, NOR_, SLT, SLTU,
            SLL, SRL, SRA, 6'h3F, 6'h01, 6'h21};
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    lit("rst", 8'h00, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    run_op("add", ADD, 8'h7F, 8'h01, 0,
           8'h80, 1, 0, 0, 1, 0);
    run_op("sub", SUB, 8'h05, 8'h05, 0,
           8'h00, 0, 1, 1, 0, 0);
    run_op("slt", SLT, 8'hFF, 8'h01, 0,
           8'h01, 0, 0, 0, 0, 0);
    run_op("sltu", SLTU, 8'hFF, 8'h01, 0,
           8'h00, 0, 0, 1, 0, 0);

    issue(SRA, 8'h80, 8'h00, 3);
    nb = 0;
    lat = 0;
    got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) begin
        got = 1;
      end else begin
        if (busy) nb++;
        op = ADD;
        in_valid = i[0];
      end
    end
    in_valid = 0;
    chk("sra_busy_cycles", 32'(nb), 32'd3);
    chk("sra_latency", 32'(lat - 1), 32'd3);
    lit("sra", 8'hF0, 0, 0, 0, 1, 0);
    @(posedge clk);
    #1;

    run_op("srl", SRL, 8'h80, 8'h00, 3,
           8'h10, 0, 0, 0, 0, 0);
    run_op("sll", SLL, 8'h81, 8'h00, 1,
           8'h02, 0, 0, 0, 0, 0);
    run_op("sh0", SRA, 8'h9C, 8'h00, 0,
           8'h9C, 0, 0, 0, 1, 0);

    out_ready = 0;
    issue(ADD, 8'h12, 8'h34, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_res", 32'(result), 32'h46);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1;
    issue(AND_, 8'hF0, 8'h3C, 0);
    @(negedge clk);
    chk("b2b_valid", 32'(out_valid), 32'd1);
    lit("b2b", 8'h30, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    run_op("illegal", 6'b111111, 8'h12, 8'h34, 0,
           8'h00, 0, 0, 1, 0, 1);

    issue(SRL, 8'hFF, 8'h00, 6);
    repeat (2) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    lit("mid_rst", 8'h00, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1;
    @(posedge clk);
    #1;
    run_op("post_rst", XOR_, 8'hA5, 8'h0F, 0,
           8'hAA, 0, 0, 0, 1, 0);

    rdy = 0;
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || rdy) begin
        in_valid = ($urandom_range(0, 3) != 0);
        op = ops[$urandom_range(0, 13)];
        a = 8'($urandom);
        b = 8'($urandom);
        shamt = 3'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      sticky_clr = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    out_ready = 1;
    sticky_clr = 0;
    repeat (12) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
